// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one memory port between instruction fetch and data access,
//            with ack timeout. Define MEM_ARBITER_ROUND_ROBIN_EN for tie-break
//            round robin instead of fixed data priority.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    // fetch side
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    input  logic        if_flush_i,
    output logic [31:0] if_data_o,
    output logic        if_valid_o,
    output logic        stall_f_o,
    // data side
    input  logic        dm_req_i,
    input  logic        dm_we_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_wdata_i,
    output logic [31:0] dm_rdata_o,
    output logic        dm_done_o,
    output logic        stall_m_o,
    // shared memory port
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i,
    output logic        err_o
);

    localparam int               CNT_W       = $clog2(ACK_TIMEOUT + 1) + 1;
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(ACK_TIMEOUT);
    localparam bit               TIMEOUT_EN  = (ACK_TIMEOUT != 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_IFETCH = 2'd1,
        ST_DACC   = 2'd2
    } state_t;

    state_t           state_q,    state_d;
    logic [31:0]      addr_q,     addr_d;
    logic             we_q,       we_d;
    logic [31:0]      wdata_q,    wdata_d;
    logic [31:0]      if_data_q,  if_data_d;
    logic             if_valid_q, if_valid_d;
    logic [31:0]      dm_rdata_q, dm_rdata_d;
    logic             dm_done_q,  dm_done_d;
    logic             drop_q,     drop_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic             err_q,      err_d;

    logic             fetch_elig;
    logic             data_elig;
    logic             grant_if;
    logic             grant_dm;
    logic [CNT_W-1:0] cnt_inc;
    logic             timeout_hit;

    assign fetch_elig  = if_req_i & ~if_valid_q;
    assign data_elig   = dm_req_i & ~dm_done_q;
    assign cnt_inc     = cnt_q + 1'b1;
    assign timeout_hit = TIMEOUT_EN && (cnt_inc == TIMEOUT_CNT);

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    logic last_data_q, last_data_d;

    // On a tie the side that did not win last time goes first.
    always_comb begin
        grant_if = 1'b0;
        grant_dm = 1'b0;
        if (fetch_elig && data_elig) begin
            grant_if = last_data_q;
            grant_dm = ~last_data_q;
        end else begin
            grant_if = fetch_elig;
            grant_dm = data_elig;
        end
    end

    always_comb begin
        last_data_d = last_data_q;
        if (state_q == ST_IDLE) begin
            if (grant_dm) begin
                last_data_d = 1'b1;
            end else if (grant_if) begin
                last_data_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_data_q <= 1'b1;
        end else begin
            last_data_q <= last_data_d;
        end
    end
`else
    always_comb begin
        grant_dm = data_elig;
        grant_if = fetch_elig & ~data_elig;
    end
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        if_data_d  = if_data_q;
        if_valid_d = 1'b0;
        dm_rdata_d = dm_rdata_q;
        dm_done_d  = 1'b0;
        drop_d     = drop_q;
        cnt_d      = cnt_q;
        err_d      = err_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_dm) begin
                    state_d = ST_DACC;
                    addr_d  = dm_addr_i;
                    we_d    = dm_we_i;
                    wdata_d = dm_wdata_i;
                    cnt_d   = '0;
                end else if (grant_if) begin
                    state_d = ST_IFETCH;
                    addr_d  = if_addr_i;
                    we_d    = 1'b0;
                    cnt_d   = '0;
                end
            end

            ST_IFETCH: begin
                if (mem_ack_i) begin
                    state_d = ST_IDLE;
                    drop_d  = 1'b0;
                    // A flush seen on the ack cycle itself also discards the word.
                    if (!(drop_q || if_flush_i)) begin
                        if_data_d  = mem_rdata_i;
                        if_valid_d = 1'b1;
                    end
                end else if (timeout_hit) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                    drop_d  = 1'b0;
                end else begin
                    cnt_d = cnt_inc;
                    if (if_flush_i) begin
                        drop_d = 1'b1;
                    end
                end
            end

            ST_DACC: begin
                if (mem_ack_i) begin
                    state_d   = ST_IDLE;
                    dm_done_d = 1'b1;
                    if (!we_q) begin
                        dm_rdata_d = mem_rdata_i;
                    end
                end else if (timeout_hit) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                    drop_d  = 1'b0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            if_data_q  <= '0;
            if_valid_q <= 1'b0;
            dm_rdata_q <= '0;
            dm_done_q  <= 1'b0;
            drop_q     <= 1'b0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            if_data_q  <= if_data_d;
            if_valid_q <= if_valid_d;
            dm_rdata_q <= dm_rdata_d;
            dm_done_q  <= dm_done_d;
            drop_q     <= drop_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    assign mem_req_o   = (state_q != ST_IDLE);
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign if_data_o   = if_data_q;
    assign if_valid_o  = if_valid_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign dm_done_o   = dm_done_q;
    assign err_o       = err_q;
    assign stall_f_o   = if_req_i & ~if_valid_q;
    assign stall_m_o   = dm_req_i & ~dm_done_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed self-checking bench for mem_arbiter (ACK_TIMEOUT = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        if_req_i, if_flush_i, dm_req_i, dm_we_i, mem_ack_i;
    logic [31:0] if_addr_i, dm_addr_i, dm_wdata_i, mem_rdata_i;
    logic [31:0] if_data_o, dm_rdata_o, mem_addr_o, mem_wdata_o;
    logic        if_valid_o, stall_f_o, dm_done_o, stall_m_o;
    logic        mem_req_o, mem_we_o, err_o;

    int n_asserts = 0;
    int n_fail    = 0;

    logic [31:0] exp_if_data, exp_dm_rdata;

    mem_arbiter #(.ACK_TIMEOUT(4)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_flush_i  (if_flush_i),
        .if_data_o   (if_data_o),
        .if_valid_o  (if_valid_o),
        .stall_f_o   (stall_f_o),
        .dm_req_i    (dm_req_i),
        .dm_we_i     (dm_we_i),
        .dm_addr_i   (dm_addr_i),
        .dm_wdata_i  (dm_wdata_i),
        .dm_rdata_o  (dm_rdata_o),
        .dm_done_o   (dm_done_o),
        .stall_m_o   (stall_m_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".mem_req"},   32'(mem_req_o),  32'd0);
        chk({tag, ".mem_we"},    32'(mem_we_o),   32'd0);
        chk({tag, ".mem_addr"},  mem_addr_o,      32'd0);
        chk({tag, ".mem_wdata"}, mem_wdata_o,     32'd0);
        chk({tag, ".if_data"},   if_data_o,       32'd0);
        chk({tag, ".if_valid"},  32'(if_valid_o), 32'd0);
        chk({tag, ".dm_rdata"},  dm_rdata_o,      32'd0);
        chk({tag, ".dm_done"},   32'(dm_done_o),  32'd0);
        chk({tag, ".err"},       32'(err_o),      32'd0);
    endtask

    initial begin
        rst_i = 1'b1;
        if_req_i = 1'b0; if_flush_i = 1'b0; if_addr_i = '0;
        dm_req_i = 1'b0; dm_we_i = 1'b0; dm_addr_i = '0; dm_wdata_i = '0;
        mem_ack_i = 1'b0; mem_rdata_i = '0;
        repeat (2) tick();
        chk_all_zero("reset");
        rst_i = 1'b0;
        tick();

        // Single fetch, ack one cycle after mem_req_o
        if_req_i = 1'b1; if_addr_i = 32'h0000_0040; #1;
        chk("f1.stall_req",  32'(stall_f_o), 32'd1);
        chk("f1.idle_req",   32'(mem_req_o), 32'd0);
        tick();
        chk("f1.mem_req",    32'(mem_req_o), 32'd1);
        chk("f1.mem_addr",   mem_addr_o, 32'h0000_0040);
        chk("f1.mem_we",     32'(mem_we_o), 32'd0);
        chk("f1.no_valid",   32'(if_valid_o), 32'd0);
        tick();
        chk("f1.mem_req2",   32'(mem_req_o), 32'd1);
        mem_ack_i = 1'b1; mem_rdata_i = 32'h2402_0005;
        tick();
        mem_ack_i = 1'b0;
        chk("f1.valid",      32'(if_valid_o), 32'd1);
        chk("f1.data",       if_data_o, 32'h2402_0005);
        chk("f1.stall_low",  32'(stall_f_o), 32'd0);
        if_req_i = 1'b0;
        tick();
        chk("f1.valid_end",  32'(if_valid_o), 32'd0);
        chk("f1.data_hold",  if_data_o, 32'h2402_0005);
        chk("f1.idle",       32'(mem_req_o), 32'd0);

        // Simultaneous fetch and load after reset (last grant = data)
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        if_req_i = 1'b1; if_addr_i = 32'h0000_0300;
        dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h0000_0100;
        #1;
        chk("tie.stall_f", 32'(stall_f_o), 32'd1);
        chk("tie.stall_m", 32'(stall_m_o), 32'd1);
        tick();
        chk("tie.first_addr", mem_addr_o, RR ? 32'h0000_0300 : 32'h0000_0100);
        chk("tie.first_we",   32'(mem_we_o), 32'd0);
        mem_ack_i = 1'b1; mem_rdata_i = 32'hA5A5_0001;
        tick();
        mem_ack_i = 1'b0;
        chk("tie.first_idle", 32'(mem_req_o), 32'd0);
        if (RR) begin
            chk("tie.if_valid1", 32'(if_valid_o), 32'd1);
            chk("tie.dm_done1",  32'(dm_done_o), 32'd0);
            chk("tie.if_data1",  if_data_o, 32'hA5A5_0001);
            chk("tie.stall_m1",  32'(stall_m_o), 32'd1);
            if_req_i = 1'b0;
        end else begin
            chk("tie.dm_done1",  32'(dm_done_o), 32'd1);
            chk("tie.if_valid1", 32'(if_valid_o), 32'd0);
            chk("tie.dm_rdata1", dm_rdata_o, 32'hA5A5_0001);
            chk("tie.stall_f1",  32'(stall_f_o), 32'd1);
            dm_req_i = 1'b0;
        end
        tick();
        chk("tie.second_req",  32'(mem_req_o), 32'd1);
        chk("tie.second_addr", mem_addr_o, RR ? 32'h0000_0100 : 32'h0000_0300);
        mem_ack_i = 1'b1; mem_rdata_i = 32'h5A5A_0002;
        tick();
        mem_ack_i = 1'b0;
        if (RR) begin
            chk("tie.dm_done2",  32'(dm_done_o), 32'd1);
            chk("tie.dm_rdata2", dm_rdata_o, 32'h5A5A_0002);
            dm_req_i = 1'b0;
            exp_if_data = 32'hA5A5_0001; exp_dm_rdata = 32'h5A5A_0002;
        end else begin
            chk("tie.if_valid2", 32'(if_valid_o), 32'd1);
            chk("tie.if_data2",  if_data_o, 32'h5A5A_0002);
            if_req_i = 1'b0;
            exp_if_data = 32'h5A5A_0002; exp_dm_rdata = 32'hA5A5_0001;
        end
        tick();

        // Flush during an in-flight fetch, then the redirected fetch
        if_req_i = 1'b1; if_addr_i = 32'h0000_0500;
        tick();
        chk("fl.mem_addr", mem_addr_o, 32'h0000_0500);
        if_flush_i = 1'b1;
        tick();
        if_flush_i = 1'b0; if_addr_i = 32'h0000_0080;
        tick();
        tick();
        chk("fl.still_busy", 32'(mem_req_o), 32'd1);
        mem_ack_i = 1'b1; mem_rdata_i = 32'hBAD0_BAD0;
        tick();
        mem_ack_i = 1'b0;
        chk("fl.no_valid",  32'(if_valid_o), 32'd0);
        chk("fl.data_hold", if_data_o, exp_if_data);
        chk("fl.idle",      32'(mem_req_o), 32'd0);
        tick();
        chk("fl.new_addr",  mem_addr_o, 32'h0000_0080);
        chk("fl.new_req",   32'(mem_req_o), 32'd1);
        mem_ack_i = 1'b1; mem_rdata_i = 32'h0000_0013;
        tick();
        mem_ack_i = 1'b0;
        chk("fl.new_valid", 32'(if_valid_o), 32'd1);
        chk("fl.new_data",  if_data_o, 32'h0000_0013);
        if_req_i = 1'b0;
        tick();

        // Store: port held until ack, load data register untouched
        dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h0000_0200; dm_wdata_i = 32'hDEAD_BEEF;
        tick();
        chk("st.we",    32'(mem_we_o), 32'd1);
        chk("st.addr",  mem_addr_o, 32'h0000_0200);
        chk("st.wdata", mem_wdata_o, 32'hDEAD_BEEF);
        dm_addr_i = 32'h0000_0999; dm_wdata_i = 32'h0; dm_we_i = 1'b0;
        tick();
        chk("st.wdata_hold", mem_wdata_o, 32'hDEAD_BEEF);
        chk("st.we_hold",    32'(mem_we_o), 32'd1);
        chk("st.addr_hold",  mem_addr_o, 32'h0000_0200);
        mem_ack_i = 1'b1; mem_rdata_i = 32'h1234_5678;
        tick();
        mem_ack_i = 1'b0;
        chk("st.done",       32'(dm_done_o), 32'd1);
        chk("st.rdata_keep", dm_rdata_o, exp_dm_rdata);
        chk("st.stall_m",    32'(stall_m_o), 32'd0);
        dm_req_i = 1'b0;
        tick();

        // Ack timeout after four busy cycles
        chk("to.err_before", 32'(err_o), 32'd0);
        if_req_i = 1'b1; if_addr_i = 32'h0000_0600;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("to.busy%0d", i), 32'(mem_req_o), 32'd1);
            tick();
        end
        chk("to.idle",     32'(mem_req_o), 32'd0);
        chk("to.err",      32'(err_o), 32'd1);
        chk("to.no_valid", 32'(if_valid_o), 32'd0);
        if_req_i = 1'b0;
        tick();
        chk("to.err_sticky", 32'(err_o), 32'd1);
        chk("to.no_valid2",  32'(if_valid_o), 32'd0);

        // Reset in the middle of a fetch; late ack must be ignored
        if_req_i = 1'b1; if_addr_i = 32'h0000_0700;
        tick();
        chk("rs.busy", 32'(mem_req_o), 32'd1);
        rst_i = 1'b1;
        tick();
        chk_all_zero("rs");
        rst_i = 1'b0; if_req_i = 1'b0;
        mem_ack_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
        tick();
        mem_ack_i = 1'b0;
        chk("rs.late_valid", 32'(if_valid_o), 32'd0);
        chk("rs.late_done",  32'(dm_done_o), 32'd0);
        chk("rs.late_data",  if_data_o, 32'd0);
        tick();
        chk("rs.idle",       32'(mem_req_o), 32'd0);
        chk("rs.no_valid",   32'(if_valid_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
